// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter request, hazard query and write-port bundle
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic [4:0]      a_addr;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [4:0]      b_addr;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            iss_en;
  logic [4:0]      iss_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  iss_en, iss_addr, rs1_addr, rs2_addr,
    output a_ready, b_ready, rs1_busy, rs2_busy, rd_en, rd_addr, rd_data
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output iss_en, iss_addr, rs1_addr, rs2_addr,
    input  a_ready, b_ready, rs1_busy, rs2_busy, rd_en, rd_addr, rd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin two-source register writeback arbiter with busy scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  // last_b_q = 1 means source B won the most recent transfer
  logic            last_b_q, last_b_d;
  logic            rd_en_q, rd_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [31:0]     busy_q, busy_d;

  logic            a_grant, b_grant;
  logic            a_fire, b_fire, any_fire;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;
  logic [31:0]     set_mask, clr_mask;

  // Grant: a lone requester wins at once; on contention the source that did not win last time goes.
  // Both grants are forced low while reset is held.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (rst) begin
      a_grant = bus.a_valid && (!bus.b_valid || last_b_q);
      b_grant = bus.b_valid && (!bus.a_valid || !last_b_q);
    end
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;
  assign a_fire      = bus.a_valid && a_grant;
  assign b_fire      = bus.b_valid && b_grant;
  assign any_fire    = a_fire || b_fire;
  assign win_addr    = a_fire ? bus.a_addr : bus.b_addr;
  assign win_data    = a_fire ? bus.a_data : bus.b_data;

  // Next state: register the winning write (x0 writes are accepted but suppressed), update the scoreboard
  always_comb begin
    last_b_d  = last_b_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    set_mask  = 32'd0;
    clr_mask  = 32'd0;
    if (a_fire) begin
      last_b_d = 1'b0;
    end else if (b_fire) begin
      last_b_d = 1'b1;
    end
    if (any_fire && (win_addr != 5'd0)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = win_addr;
      rd_data_d = win_data;
      clr_mask  = 32'd1 << win_addr;
    end
    if (bus.iss_en && (bus.iss_addr != 5'd0)) begin
      set_mask = 32'd1 << bus.iss_addr;
    end
    // Set is applied after clear so a same-address issue keeps the bit set
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  // State registers; reset leaves B as last winner so A takes the first contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q  <= 1'b1;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= '0;
      busy_q    <= 32'd0;
    end else begin
      last_b_q  <= last_b_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   fails;

  regfile_wb_arbiter_if #(.XLEN(32)) bus ();

  regfile_wb_arbiter #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.iss_en  = 1'b0;
  endtask

  logic [4:0] exp_addr [4];
  logic       exp_a    [4];

  initial begin
    vectors = 0;
    fails   = 0;
    rst     = 1'b0;
    bus.a_valid  = 1'b0;
    bus.a_addr   = 5'd0;
    bus.a_data   = 32'd0;
    bus.b_valid  = 1'b0;
    bus.b_addr   = 5'd0;
    bus.b_data   = 32'd0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = 5'd0;
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;

    // Reset state, including readies held low against active requests
    tick();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.rs1_addr = 5'd12;
    #1;
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check("rst_busy", 32'(bus.rs1_busy), 32'd0);
    idle_inputs();
    #2;
    rst = 1'b1;
    tick();

    // Contention for 4 cycles: A,B,A,B
    exp_addr[0] = 5'd3; exp_addr[1] = 5'd7; exp_addr[2] = 5'd3; exp_addr[3] = 5'd7;
    exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h0000_0033;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h0000_0077;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_a_ready%0d", i), 32'(bus.a_ready), 32'(exp_a[i]));
      check($sformatf("rr_b_ready%0d", i), 32'(bus.b_ready), 32'(!exp_a[i]));
      tick();
      check($sformatf("rr_rd_en%0d", i), 32'(bus.rd_en), 32'd1);
      check($sformatf("rr_rd_addr%0d", i), 32'(bus.rd_addr), 32'(exp_addr[i]));
    end
    idle_inputs();
    tick();
    check("idle_rd_en", 32'(bus.rd_en), 32'd0);
    check("idle_rd_addr_hold", 32'(bus.rd_addr), 32'd7);
    check("idle_rd_data_hold", bus.rd_data, 32'h0000_0077);

    // A alone: granted same cycle, written next cycle
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
    #1;
    check("a_only_ready", 32'(bus.a_ready), 32'd1);
    check("a_only_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    check("a_only_rd_en", 32'(bus.rd_en), 32'd1);
    check("a_only_rd_addr", 32'(bus.rd_addr), 32'd5);
    check("a_only_rd_data", bus.rd_data, 32'hDEAD_BEEF);
    idle_inputs();

    // Issue marks x9 busy; a B write to x9 clears it
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd9;
    #1;
    check("busy9_no_bypass", 32'(bus.rs1_busy), 32'd0);
    tick();
    bus.iss_en = 1'b0;
    #1;
    check("busy9_rs1_set", 32'(bus.rs1_busy), 32'd1);
    check("busy9_rs2_set", 32'(bus.rs2_busy), 32'd1);
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h0000_0999;
    #1;
    check("b_only_ready", 32'(bus.b_ready), 32'd1);
    check("b_only_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    bus.b_valid = 1'b0;
    #1;
    check("busy9_rs1_clr", 32'(bus.rs1_busy), 32'd0);
    check("b9_rd_en", 32'(bus.rd_en), 32'd1);
    check("b9_rd_addr", 32'(bus.rd_addr), 32'd9);
    check("b9_rd_data", bus.rd_data, 32'h0000_0999);

    // Issue and write of x4 in the same cycle: set wins
    bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h0000_0444;
    bus.rs1_addr = 5'd4;
    tick();
    idle_inputs();
    #1;
    check("x4_rd_en", 32'(bus.rd_en), 32'd1);
    check("x4_rd_addr", 32'(bus.rd_addr), 32'd4);
    check("x4_busy_set_wins", 32'(bus.rs1_busy), 32'd1);

    // Issue x10 while writing x4: both take effect
    bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
    bus.a_valid = 1'b1; bus.a_addr = 5'd4; bus.a_data = 32'h0000_0404;
    bus.rs2_addr = 5'd10;
    tick();
    idle_inputs();
    #1;
    check("x4_busy_cleared", 32'(bus.rs1_busy), 32'd0);
    check("x10_busy_set", 32'(bus.rs2_busy), 32'd1);

    // Write to x0: accepted but no register write
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h0000_1234;
    bus.rs1_addr = 5'd0;
    #1;
    check("x0_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("x0_rd_en", 32'(bus.rd_en), 32'd0);
    check("x0_rd_addr_hold", 32'(bus.rd_addr), 32'd4);
    check("x0_rs1_busy", 32'(bus.rs1_busy), 32'd0);

    // Last winner is A; an idle cycle must not change that, so contention goes to B
    tick();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h0000_0001;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h0000_0002;
    #1;
    check("hold_flag_b_ready", 32'(bus.b_ready), 32'd1);
    check("hold_flag_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    idle_inputs();
    check("hold_flag_rd_addr", 32'(bus.rd_addr), 32'd2);

    // Reset mid-cycle with a pending transfer and x12 busy
    bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
    bus.a_valid = 1'b1; bus.a_addr = 5'd13; bus.a_data = 32'h0000_0013;
    bus.rs1_addr = 5'd12;
    tick();
    bus.iss_en = 1'b0;
    bus.a_addr = 5'd14; bus.a_data = 32'h0000_0014;
    #1;
    check("pre_rst_rd_en", 32'(bus.rd_en), 32'd1);
    check("pre_rst_busy12", 32'(bus.rs1_busy), 32'd1);
    check("pre_rst_a_ready", 32'(bus.a_ready), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("mid_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("mid_rst_busy12", 32'(bus.rs1_busy), 32'd0);
    check("mid_rst_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    tick();
    check("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h0000_0A03;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h0000_0B07;
    #1;
    check("post_rst_a_first", 32'(bus.a_ready), 32'd1);
    check("post_rst_b_wait", 32'(bus.b_ready), 32'd0);
    tick();
    idle_inputs();
    check("post_rst_rd_addr", 32'(bus.rd_addr), 32'd3);
    check("post_rst_rd_data", bus.rd_data, 32'h0000_0A03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
